// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the alu_arbiter slice.
// ALUOP_* codes mirror the ALU's opcode map; ADD is 0.
package alu_arbiter_pkg;

   localparam int XLEN     = 32;
   localparam int OPW      = 5;
   localparam int PORT_IDW = 1;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;
   localparam logic [1:0] ARB_RESP  = 2'd3;

   localparam logic [OPW-1:0] ALUOP_ADD  = 5'd0;
   localparam logic [OPW-1:0] ALUOP_SUB  = 5'd1;
   localparam logic [OPW-1:0] ALUOP_SLL  = 5'd2;
   localparam logic [OPW-1:0] ALUOP_SRL  = 5'd6;
   localparam logic [OPW-1:0] ALUOP_SRA  = 5'd7;
   localparam logic [OPW-1:0] ALUOP_DIV  = 5'd14;
   localparam logic [OPW-1:0] ALUOP_DIVU = 5'd15;
   localparam logic [OPW-1:0] ALUOP_REM  = 5'd16;
   localparam logic [OPW-1:0] ALUOP_REMU = 5'd17;

   typedef struct packed {
      logic [XLEN-1:0]     s1;
      logic [XLEN-1:0]     s2;
      logic [OPW-1:0]      op;
      logic [PORT_IDW-1:0] owner;
   } arb_req_t;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            lt;
      logic            ltu;
      logic            eq;
   } arb_rsp_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Grant selection between the two requesters.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin; default is port 0 priority.
module alu_arb_pick
   import alu_arbiter_pkg::*;
(
   input  logic I_valid0,
   input  logic I_valid1,
   input  logic I_last,
   output logic O_any,
   output logic O_grant
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
   always_comb begin
      O_any = I_valid0 | I_valid1;
      // On contention the port not granted last wins
      if (I_valid0 && I_valid1) O_grant = ~I_last;
      else                      O_grant = I_valid1;
   end
`else
   logic unused_last;
   assign unused_last = I_last;

   always_comb begin
      O_any   = I_valid0 | I_valid1;
      O_grant = ~I_valid0 & I_valid1;
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between execute (port 0) and check unit (port 1).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration on contention.
module alu_arbiter
   import alu_arbiter_pkg::*;
(
   input  logic            I_clk,
   input  logic            I_reset,
   input  logic            I_req0_valid,
   output logic            O_req0_ready,
   input  logic [XLEN-1:0] I_req0_s1,
   input  logic [XLEN-1:0] I_req0_s2,
   input  logic [OPW-1:0]  I_req0_op,
   input  logic            I_req1_valid,
   output logic            O_req1_ready,
   input  logic [XLEN-1:0] I_req1_s1,
   input  logic [XLEN-1:0] I_req1_s2,
   input  logic [OPW-1:0]  I_req1_op,
   output logic            O_rsp0_valid,
   input  logic            I_rsp0_ready,
   output logic            O_rsp1_valid,
   input  logic            I_rsp1_ready,
   output logic [XLEN-1:0] O_rsp_data,
   output logic            O_rsp_lt,
   output logic            O_rsp_ltu,
   output logic            O_rsp_eq,
   output logic            O_alu_en,
   output logic [XLEN-1:0] O_alu_s1,
   output logic [XLEN-1:0] O_alu_s2,
   output logic [OPW-1:0]  O_alu_op,
   input  logic            I_alu_busy,
   input  logic [XLEN-1:0] I_alu_data,
   input  logic            I_alu_lt,
   input  logic            I_alu_ltu,
   input  logic            I_alu_eq
);

   logic [1:0] state_q, state_d;
   arb_req_t   req_q, req_d;
   arb_rsp_t   rsp_q, rsp_d;
   logic       last_q, last_d;

   logic any_valid;
   logic grant;
   logic is_idle;
   logic owner_ready;

   alu_arb_pick u_pick (
      .I_valid0 (I_req0_valid),
      .I_valid1 (I_req1_valid),
      .I_last   (last_q),
      .O_any    (any_valid),
      .O_grant  (grant)
   );

   assign is_idle     = (state_q == ARB_IDLE);
   assign owner_ready = req_q.owner[0] ? I_rsp1_ready : I_rsp0_ready;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rsp_d   = rsp_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_valid) begin
               req_d.s1    = grant ? I_req1_s1 : I_req0_s1;
               req_d.s2    = grant ? I_req1_s2 : I_req0_s2;
               req_d.op    = grant ? I_req1_op : I_req0_op;
               req_d.owner = grant;
               last_d      = grant;
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: state_d = ARB_WAIT;
         ARB_WAIT: begin
            if (!I_alu_busy) begin
               rsp_d.data = I_alu_data;
               rsp_d.lt   = I_alu_lt;
               rsp_d.ltu  = I_alu_ltu;
               rsp_d.eq   = I_alu_eq;
               state_d    = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (owner_ready) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state_q <= ARB_IDLE;
         req_q   <= '0;
         rsp_q   <= '0;
         // Pointer "last = 1" favours port 0 first
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rsp_q   <= rsp_d;
         last_q  <= last_d;
      end
   end

   assign O_req0_ready = is_idle & I_req0_valid & ~grant;
   assign O_req1_ready = is_idle & I_req1_valid & grant;

   assign O_rsp0_valid = (state_q == ARB_RESP) & ~req_q.owner[0];
   assign O_rsp1_valid = (state_q == ARB_RESP) & req_q.owner[0];
   assign O_rsp_data   = rsp_q.data;
   assign O_rsp_lt     = rsp_q.lt;
   assign O_rsp_ltu    = rsp_q.ltu;
   assign O_rsp_eq     = rsp_q.eq;

   assign O_alu_en = (state_q == ARB_ISSUE);
   assign O_alu_s1 = req_q.s1;
   assign O_alu_s2 = req_q.s2;
   assign O_alu_op = req_q.op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU.
// Contention expectations follow ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        I_clk, I_reset;
   logic        I_req0_valid, O_req0_ready;
   logic        I_req1_valid, O_req1_ready;
   logic [31:0] I_req0_s1, I_req0_s2, I_req1_s1, I_req1_s2;
   logic [4:0]  I_req0_op, I_req1_op;
   logic        O_rsp0_valid, O_rsp1_valid;
   logic        I_rsp0_ready, I_rsp1_ready;
   logic [31:0] O_rsp_data;
   logic        O_rsp_lt, O_rsp_ltu, O_rsp_eq;
   logic        O_alu_en;
   logic [31:0] O_alu_s1, O_alu_s2;
   logic [4:0]  O_alu_op;
   logic        I_alu_busy;
   logic [31:0] I_alu_data;
   logic        I_alu_lt, I_alu_ltu, I_alu_eq;

   int checks;
   int errors;
   logic [5:0] busy_cnt;

   alu_arbiter dut (
      .I_clk        (I_clk),
      .I_reset      (I_reset),
      .I_req0_valid (I_req0_valid),
      .O_req0_ready (O_req0_ready),
      .I_req0_s1    (I_req0_s1),
      .I_req0_s2    (I_req0_s2),
      .I_req0_op    (I_req0_op),
      .I_req1_valid (I_req1_valid),
      .O_req1_ready (O_req1_ready),
      .I_req1_s1    (I_req1_s1),
      .I_req1_s2    (I_req1_s2),
      .I_req1_op    (I_req1_op),
      .O_rsp0_valid (O_rsp0_valid),
      .I_rsp0_ready (I_rsp0_ready),
      .O_rsp1_valid (O_rsp1_valid),
      .I_rsp1_ready (I_rsp1_ready),
      .O_rsp_data   (O_rsp_data),
      .O_rsp_lt     (O_rsp_lt),
      .O_rsp_ltu    (O_rsp_ltu),
      .O_rsp_eq     (O_rsp_eq),
      .O_alu_en     (O_alu_en),
      .O_alu_s1     (O_alu_s1),
      .O_alu_s2     (O_alu_s2),
      .O_alu_op     (O_alu_op),
      .I_alu_busy   (I_alu_busy),
      .I_alu_data   (I_alu_data),
      .I_alu_lt     (I_alu_lt),
      .I_alu_ltu    (I_alu_ltu),
      .I_alu_eq     (I_alu_eq)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   // Behavioural ALU: busy k+1 cycles for shifts, 33 for divides
   always @(posedge I_clk) begin
      if (I_reset) begin
         busy_cnt   <= '0;
         I_alu_data <= '0;
         I_alu_lt   <= 1'b0;
         I_alu_ltu  <= 1'b0;
         I_alu_eq   <= 1'b0;
      end else if (O_alu_en) begin
         I_alu_lt  <= $signed(O_alu_s1) < $signed(O_alu_s2);
         I_alu_ltu <= O_alu_s1 < O_alu_s2;
         I_alu_eq  <= O_alu_s1 == O_alu_s2;
         case (O_alu_op)
            ALUOP_SLL: begin
               I_alu_data <= O_alu_s1 << O_alu_s2[4:0];
               busy_cnt   <= {1'b0, O_alu_s2[4:0]} + 6'd1;
            end
            ALUOP_DIV: begin
               if (O_alu_s2 == 32'd0) begin
                  I_alu_data <= '1;
                  busy_cnt   <= '0;
               end else begin
                  I_alu_data <= $signed(O_alu_s1) / $signed(O_alu_s2);
                  busy_cnt   <= 6'd33;
               end
            end
            default: begin
               I_alu_data <= O_alu_s1 + O_alu_s2;
               busy_cnt   <= '0;
            end
         endcase
      end else if (busy_cnt != 6'd0) begin
         busy_cnt <= busy_cnt - 6'd1;
      end
   end

   assign I_alu_busy = (busy_cnt != 6'd0);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic do_req(input int p, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] op,
                         output int waits);
      if (p == 0) begin
         I_req0_s1 = a; I_req0_s2 = b; I_req0_op = op; I_req0_valid = 1'b1;
      end else begin
         I_req1_s1 = a; I_req1_s2 = b; I_req1_op = op; I_req1_valid = 1'b1;
      end
      waits = -1;
      for (int i = 0; i < 64; i++) begin
         #1;
         if ((p == 0 && O_req0_ready) || (p == 1 && O_req1_ready)) begin
            waits = i;
            break;
         end
         tick();
      end
      tick();
      if (p == 0) I_req0_valid = 1'b0;
      else        I_req1_valid = 1'b0;
   endtask

   task automatic test_reset();
      I_reset = 1'b1;
      tick();
      tick();
      checks += 8;
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp0_valid: got %b want 0", O_rsp0_valid); end
      if (O_rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp1_valid: got %b want 0", O_rsp1_valid); end
      if (O_alu_en !== 1'b0) begin errors++; $display("FAIL rst_alu_en: got %b want 0", O_alu_en); end
      if (O_alu_s1 !== 32'd0) begin errors++; $display("FAIL rst_alu_s1: got %h want 0", O_alu_s1); end
      if (O_alu_s2 !== 32'd0) begin errors++; $display("FAIL rst_alu_s2: got %h want 0", O_alu_s2); end
      if (O_alu_op !== ALUOP_ADD) begin errors++; $display("FAIL rst_alu_op: got %h want 0", O_alu_op); end
      if (O_rsp_data !== 32'd0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", O_rsp_data); end
      if ({O_rsp_lt, O_rsp_ltu, O_rsp_eq} !== 3'b000) begin
         errors++; $display("FAIL rst_flags: got %b want 000", {O_rsp_lt, O_rsp_ltu, O_rsp_eq});
      end
      I_reset = 1'b0;
      I_req1_valid = 1'b1;
      #1;
      checks += 2;
      if (O_req1_ready !== 1'b1) begin errors++; $display("FAIL rst_ready1_only: got %b want 1", O_req1_ready); end
      if (O_req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0_idle: got %b want 0", O_req0_ready); end
      I_req0_valid = 1'b1;
      #1;
      checks += 2;
      if (O_req0_ready !== 1'b1) begin errors++; $display("FAIL rst_ready0_both: got %b want 1", O_req0_ready); end
      if (O_req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1_both: got %b want 0", O_req1_ready); end
      I_req0_valid = 1'b0;
      I_req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_basic_add();
      int w;
      do_req(0, 32'd5, 32'd7, ALUOP_ADD, w);
      checks += 2;
      if (w !== 0) begin errors++; $display("FAIL add_handshake: waits %0d want 0", w); end
      if (O_alu_en !== 1'b1) begin errors++; $display("FAIL add_en_n1: got %b want 1", O_alu_en); end
      tick();
      checks += 2;
      if (O_alu_en !== 1'b0) begin errors++; $display("FAIL add_en_n2: got %b want 0", O_alu_en); end
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp: got %b want 0", O_rsp0_valid); end
      tick();
      checks += 6;
      if (O_rsp0_valid !== 1'b1) begin errors++; $display("FAIL add_rsp0_valid: got %b want 1", O_rsp0_valid); end
      if (O_rsp1_valid !== 1'b0) begin errors++; $display("FAIL add_rsp1_valid: got %b want 0", O_rsp1_valid); end
      if (O_rsp_data !== 32'd12) begin errors++; $display("FAIL add_data: got %h want c", O_rsp_data); end
      if (O_rsp_eq !== 1'b0) begin errors++; $display("FAIL add_eq: got %b want 0", O_rsp_eq); end
      if (O_rsp_lt !== 1'b1) begin errors++; $display("FAIL add_lt: got %b want 1", O_rsp_lt); end
      if (O_rsp_ltu !== 1'b1) begin errors++; $display("FAIL add_ltu: got %b want 1", O_rsp_ltu); end
      tick();
      checks++;
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_taken: got %b want 0", O_rsp0_valid); end
   endtask

   task automatic test_shift();
      int w, c, unstable;
      do_req(1, 32'd1, 32'd4, ALUOP_SLL, w);
      c = 1;
      unstable = 0;
      while (!O_rsp1_valid && c < 80) begin
         if (O_alu_op !== ALUOP_SLL || O_alu_s1 !== 32'd1 || O_alu_s2 !== 32'd4)
            unstable++;
         tick();
         c++;
      end
      checks += 4;
      if (c !== 8) begin errors++; $display("FAIL sll_latency: got %0d want 8", c); end
      if (O_rsp_data !== 32'h10) begin errors++; $display("FAIL sll_data: got %h want 10", O_rsp_data); end
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL sll_rsp0: got %b want 0", O_rsp0_valid); end
      if (unstable !== 0) begin errors++; $display("FAIL sll_stable: got %0d bad cycles want 0", unstable); end
      tick();
   endtask

   task automatic test_divide();
      int w, c, early;
      do_req(0, 32'hFFFF_FFEC, 32'd3, ALUOP_DIV, w);
      I_req1_s1 = 32'd2; I_req1_s2 = 32'd3; I_req1_op = ALUOP_ADD;
      I_req1_valid = 1'b1;
      c = 1;
      early = 0;
      while (!O_rsp0_valid && c < 100) begin
         #1;
         if (O_req1_ready) early++;
         tick();
         c++;
      end
      #1;
      checks += 4;
      if (c !== 36) begin errors++; $display("FAIL div_latency: got %0d want 36", c); end
      if (O_rsp_data !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_data: got %h want fffffffa", O_rsp_data); end
      if (early !== 0) begin errors++; $display("FAIL div_early_ready: got %0d want 0", early); end
      if (O_req1_ready !== 1'b0) begin errors++; $display("FAIL div_ready_resp: got %b want 0", O_req1_ready); end
      tick();
      #1;
      checks++;
      if (O_req1_ready !== 1'b1) begin errors++; $display("FAIL div_ready_after: got %b want 1", O_req1_ready); end
      tick();
      I_req1_valid = 1'b0;
      tick();
      tick();
      checks += 3;
      if (O_rsp1_valid !== 1'b1) begin errors++; $display("FAIL div_p1_valid: got %b want 1", O_rsp1_valid); end
      if (O_rsp_data !== 32'd5) begin errors++; $display("FAIL div_p1_data: got %h want 5", O_rsp_data); end
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL div_p1_rsp0: got %b want 0", O_rsp0_valid); end
      tick();
   endtask

   task automatic test_contention();
      int got, exp_port, c;
      logic [31:0] exp_data;
      I_req0_s1 = 32'd10; I_req0_s2 = 32'd1; I_req0_op = ALUOP_ADD;
      I_req1_s1 = 32'd20; I_req1_s2 = 32'd2; I_req1_op = ALUOP_ADD;
      I_req0_valid = 1'b1;
      I_req1_valid = 1'b1;
      for (int t = 0; t < 4; t++) begin
         got = -1;
         for (int i = 0; i < 64 && got < 0; i++) begin
            #1;
            if (O_req0_ready) got = 0;
            else if (O_req1_ready) got = 1;
            else tick();
         end
`ifdef ALU_ARB_ROUND_ROBIN_EN
         exp_port = t % 2;
`else
         exp_port = 0;
`endif
         exp_data = (exp_port == 1) ? 32'd22 : 32'd11;
         checks++;
         if (got !== exp_port) begin errors++; $display("FAIL cont_grant%0d: got %0d want %0d", t, got, exp_port); end
         tick();
         c = 0;
         while (!(O_rsp0_valid || O_rsp1_valid) && c < 64) begin
            tick();
            c++;
         end
         checks++;
         if (O_rsp_data !== exp_data) begin errors++; $display("FAIL cont_data%0d: got %h want %h", t, O_rsp_data, exp_data); end
         tick();
      end
      I_req0_valid = 1'b0;
      I_req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      int w;
      I_rsp0_ready = 1'b0;
      do_req(0, 32'd100, 32'd23, ALUOP_ADD, w);
      tick();
      tick();
      I_req1_s1 = 32'd1; I_req1_s2 = 32'd1; I_req1_op = ALUOP_ADD;
      I_req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks += 3;
         if (O_rsp0_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", i, O_rsp0_valid); end
         if (O_rsp_data !== 32'd123) begin errors++; $display("FAIL bp_data%0d: got %h want 7b", i, O_rsp_data); end
         if (O_req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, O_req1_ready); end
         tick();
      end
      I_rsp0_ready = 1'b1;
      #1;
      checks++;
      if (O_rsp0_valid !== 1'b1) begin errors++; $display("FAIL bp_final_valid: got %b want 1", O_rsp0_valid); end
      tick();
      #1;
      checks += 2;
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_taken: got %b want 0", O_rsp0_valid); end
      if (O_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_idle: got %b want 1", O_req1_ready); end
      I_req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_op();
      int w;
      do_req(0, 32'd100, 32'd7, ALUOP_DIV, w);
      repeat (10) tick();
      checks++;
      if (I_alu_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", I_alu_busy); end
      I_reset = 1'b1;
      tick();
      I_reset = 1'b0;
      checks += 4;
      if (O_rsp0_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp0: got %b want 0", O_rsp0_valid); end
      if (O_rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp1: got %b want 0", O_rsp1_valid); end
      if (O_alu_en !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b want 0", O_alu_en); end
      if (I_alu_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", I_alu_busy); end
      do_req(0, 32'd8, 32'd9, ALUOP_ADD, w);
      checks++;
      if (w !== 0) begin errors++; $display("FAIL rmid_idle: waits %0d want 0", w); end
      tick();
      tick();
      checks += 2;
      if (O_rsp0_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid: got %b want 1", O_rsp0_valid); end
      if (O_rsp_data !== 32'd17) begin errors++; $display("FAIL rmid_new_data: got %h want 11", O_rsp_data); end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      I_reset = 1'b1;
      I_req0_valid = 1'b0; I_req1_valid = 1'b0;
      I_req0_s1 = '0; I_req0_s2 = '0; I_req0_op = '0;
      I_req1_s1 = '0; I_req1_s2 = '0; I_req1_op = '0;
      I_rsp0_ready = 1'b1;
      I_rsp1_ready = 1'b1;
      test_reset();
      test_basic_add();
      test_shift();
      test_divide();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single multi-cycle `alu` instance between two requesters: the CPU execute stage (port 0) and the security/check unit (port 1). It holds one transaction at a time and drives the ALU operands, opcode and enable. It tracks ALU busy through shifts and divides, then returns the registered result and compare flags to the requester that owns the transaction.

## Interface
- No parameters; operand width is fixed at 32 and opcode width at 5, as in `aludefs.vh`.
- I_clk  in  1  clock
- I_reset  in  1  reset, synchronous, active-high; shared with `alu`
- I_reqN_valid  in  1  request valid, N=0,1
- O_reqN_ready  out  1  request accepted this cycle when valid&&ready
- I_reqN_s1, I_reqN_s2  in  32  operands
- I_reqN_op  in  5  ALUOP_* code
- O_rspN_valid  out  1  response valid, held until taken
- I_rspN_ready  in  1  response consumed
- O_rsp_data  out  32  result, shared by both ports
- O_rsp_lt, O_rsp_ltu, O_rsp_eq  out  1  compare flags, shared by both ports
- O_alu_en  out  1  to alu I_en
- O_alu_s1, O_alu_s2  out  32  to alu I_dataS1/I_dataS2
- O_alu_op  out  5  to alu I_aluop
- I_alu_busy  in  1  from alu O_busy
- I_alu_data  in  32  from alu O_data
- I_alu_lt, I_alu_ltu, I_alu_eq  in  1  from alu flags

## Operation
- FSM states:
  - IDLE: ready is offered to the granted valid requester (combinational, IDLE only). On handshake, latch s1/s2/op and the owner ID, then go to ISSUE.
  - ISSUE: O_alu_en=1 for exactly one cycle, then go to WAIT.
  - WAIT: O_alu_en=0. When I_alu_busy==0, capture I_alu_data and flags into the response registers, then go to RESP. Otherwise stay in WAIT.
  - RESP: O_rsp<owner>_valid=1. Leave on I_rsp<owner>_ready, then go to IDLE.
- O_alu_s1/s2/op hold the latched values from handshake until the next handshake. The ALU needs operand and op stability while busy.
- Only one transaction is outstanding. A request presented in any state other than IDLE waits.
- Simultaneous valid requests (default arbitration): port 0 always wins.
- Single-cycle ops and divide-by-zero/overflow special cases return with busy never asserted. WAIT completes on its first cycle.
- Response data for the non-owner port is don't-care. The non-owner's rsp_valid stays 0.
- Reset in any state:
  - Next state is IDLE.
  - All rsp_valid signals are 0 and O_alu_en is 0.
  - The in-flight transaction is dropped silently; the ALU clears busy on the same reset.

## Timing
- Reset values:
  - State is IDLE.
  - O_reqN_ready reflects valids combinationally.
  - O_rspN_valid=0 and O_alu_en=0.
  - O_alu_s1/s2=0, O_alu_op=0 (ADD).
  - O_rsp_data=0, all O_rsp flags=0.
  - Round-robin pointer favours port 0.
- Handshake in cycle n leads to:
  - n+1: ISSUE.
  - n+2: first WAIT.
  - Single-cycle op: rsp_valid asserted in n+3.
- Shift by k: busy high for k+1 WAIT cycles; rsp_valid at n+k+4.
- DIV/DIVU/REM/REMU (non-special): busy high for 33 cycles; rsp_valid at n+36.
- rsp_valid && rsp_ready in cycle m: IDLE in m+1. The earliest next handshake is m+1, so there is one idle bubble.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined:
  - Arbitration on contention is round-robin. The port not granted last wins.
  - The last-granted pointer updates on every handshake.
- ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 wins.

## Structure
- `alu_arb_defs.vh`:
  - state encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_RESP;
  - port ID width;
  - includes `aludefs.vh` for the ALUOP_* codes.
- Sub-module `alu_arb_pick`: combinational grant from the two valids and the last-granted bit. It holds the only ALU_ARB_ROUND_ROBIN_EN-dependent logic.

## Test plan
- Basic add:
  - Stimulus: port0 requests ADD 5+7 at cycle 10.
  - Response: O_alu_en high in cycle 11 only; rsp0_valid in cycle 13 with data 12 and eq=0; rsp1_valid stays 0.
- Shift latency:
  - Stimulus: port1 requests SLL 1<<4.
  - Response: rsp1_valid 8 cycles after the handshake with data 0x10; O_alu_op/s1/s2 stable throughout WAIT.
- Divide:
  - Stimulus: port0 requests DIV −20/3.
  - Response: rsp0 data 0xFFFFFFFA at handshake+36. A port1 request during the divide gets no ready until after rsp0 is taken.
- Contention:
  - Stimulus: both ports valid continuously with ADDs.
  - Response: port0 granted every time without ALU_ARB_ROUND_ROBIN_EN; strict alternation 0,1,0,1 with it.
- Backpressure:
  - Stimulus: rsp0_ready held low for 5 cycles.
  - Response: rsp0_valid and data held; no new ready for 5 cycles.
- Reset mid-op:
  - Stimulus: I_reset for one cycle mid-divide.
  - Response: next cycle IDLE, all rsp_valid signals 0, I_alu_busy 0; a new ADD completes normally.
